// File: rtl/bcd_display_scanner_if.sv
// Bus between the display scanner and whatever feeds it digits.
// The producer side (master) supplies the digits, decimal points and the
// scan enable; the scanner side (slave) returns the registered display drive.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [6:0]                seg;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_start;

  modport master (
    output enable, digits_in, dp_in,
    input  seg, dp_n, an, frame_start
  );

  modport slave (
    input  enable, digits_in, dp_in,
    output seg, dp_n, an, frame_start
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment driver for NUM_DIGITS BCD digits.
// A prescaler sets how long each digit is lit. The digit values are frozen
// once per frame so a digit never changes while the frame is being drawn.
// Leading zeros can be blanked, and non-BCD codes are shown as a dash.
// All display outputs are registered one cycle behind the scan index.
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4,
  parameter int LZ_BLANK   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  bcd_display_scanner_if.slave        bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            snap [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_snap;

  logic                  tick;
  logic                  last_digit;
  logic                  wrap;

  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  higher_zero;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  logic [6:0]            seg_q;
  logic                  dp_n_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_start_q;

  assign tick       = bus.enable && (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = tick && last_digit;

  // Prescaler and digit index: the index steps once every SCAN_DIV enabled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (bus.enable) begin
      if (tick) begin
        div_cnt <= '0;
        idx     <= last_digit ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Freeze the incoming digits on the same edge that the index returns to digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= 4'd0;
      dp_snap <= '0;
    end else if (wrap) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= bus.digits_in[4*i +: 4];
      dp_snap <= bus.dp_in;
    end
  end

  // Pulse for one cycle after a fresh snapshot starts at digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_start_q <= 1'b0;
    else       frame_start_q <= wrap;
  end

  // Pick the current digit and decide whether it sits inside a run of leading zeros.
  always_comb begin
    cur_digit   = 4'd0;
    cur_dp      = 1'b0;
    cur_blank   = 1'b0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (snap[i] == 4'd0);
      if (idx == IDX_W'(i)) begin
        cur_digit = snap[i];
        cur_dp    = dp_snap[i];
        cur_blank = (LZ_BLANK != 0) && (i > 0) && higher_zero;
      end
    end
  end

  // Active-low segment decode; anything above 9 shows only the middle bar.
  always_comb begin
    case (cur_digit)
      4'd0:    dec_seg = 7'h40;
      4'd1:    dec_seg = 7'h79;
      4'd2:    dec_seg = 7'h24;
      4'd3:    dec_seg = 7'h30;
      4'd4:    dec_seg = 7'h19;
      4'd5:    dec_seg = 7'h12;
      4'd6:    dec_seg = 7'h02;
      4'd7:    dec_seg = 7'h78;
      4'd8:    dec_seg = 7'h00;
      4'd9:    dec_seg = 7'h10;
      default: dec_seg = 7'h3F;
    endcase
    seg_next = cur_blank ? 7'h7F : dec_seg;
  end

  // One-cold anode select for the current index.
  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) an_next[i] = 1'b0;
    end
  end

  // Register the display drive; it freezes together with the scan when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_n_q <= 1'b1;
    end else if (bus.enable) begin
      an_q   <= an_next;
      seg_q  <= seg_next;
      dp_n_q <= ~cur_dp;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (4 digits, 4-cycle slots, blanking on).
// The reference model counts enabled cycles since reset and derives the
// slot, digit and snapshot timing arithmetically from that count.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int SD = 4;

  logic clk;
  logic reset;

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .LZ_BLANK   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          cnt;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dpn;
  logic        exp_fs;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [15:0] s, input int i);
    logic [3:0] d;
    d = s[4*i +: 4];
    if (i > 0 && (s >> (4*i)) == 16'd0) return 7'h7F;
    return seg_lut[d];
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    int top;
    v = 16'd0;
    for (int i = 0; i < ND; i++) begin
      if ($urandom_range(0, 3) == 0) v[4*i +: 4] = 4'd0;
      else                           v[4*i +: 4] = 4'($urandom_range(0, 15));
    end
    top = $urandom_range(0, ND - 1);
    for (int i = top + 1; i < ND; i++) v[4*i +: 4] = 4'd0;
    return v;
  endfunction

  task automatic model_reset();
    cnt     = 0;
    m_snap  = 16'd0;
    m_dp    = 4'd0;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dpn = 1'b1;
    exp_fs  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},   16'(bus.an),          16'h000F);
    chk({tag, "_seg"},  16'(bus.seg),         16'h007F);
    chk({tag, "_dpn"},  16'(bus.dp_n),        16'h0001);
    chk({tag, "_fs"},   16'(bus.frame_start), 16'h0000);
  endtask

  task automatic run_cycle();
    int pre_div;
    int pre_idx;
    pre_div = cnt % SD;
    pre_idx = (cnt / SD) % ND;
    if (bus.enable) begin
      exp_an          = 4'hF;
      exp_an[pre_idx] = 1'b0;
      exp_seg         = seg_of(m_snap, pre_idx);
      exp_dpn         = ~m_dp[pre_idx];
      exp_fs          = (pre_div == SD - 1) && (pre_idx == ND - 1);
      if (exp_fs) begin
        m_snap = bus.digits_in;
        m_dp   = bus.dp_in;
      end
      cnt++;
    end else begin
      exp_fs = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("an",          16'(bus.an),          16'(exp_an));
    chk("seg",         16'(bus.seg),         16'(exp_seg));
    chk("dp_n",        16'(bus.dp_n),        16'(exp_dpn));
    chk("frame_start", 16'(bus.frame_start), 16'(exp_fs));
  endtask

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.digits_in = 16'($urandom);
    bus.dp_in     = 4'($urandom);
    model_reset();

    // Reset holds the display dark regardless of inputs.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      bus.digits_in = 16'($urandom);
      bus.dp_in     = 4'($urandom);
      bus.enable    = 1'($urandom);
    end

    // Release; first frame shows the all-zero snapshot, then 1234.
    bus.enable    = 1'b1;
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'b0000;
    reset         = 1'b0;
    model_reset();
    repeat (40) run_cycle();

    // Leading-zero blanking cases and invalid code with a decimal point.
    bus.digits_in = 16'h0050;
    repeat (32) run_cycle();
    bus.digits_in = 16'h0000;
    repeat (32) run_cycle();
    bus.digits_in = 16'h00A0;
    bus.dp_in     = 4'b0010;
    repeat (32) run_cycle();

    // Mid-frame change must not tear the display.
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'b0000;
    repeat (32) run_cycle();
    repeat (6) run_cycle();
    bus.digits_in = 16'h5678;
    repeat (30) run_cycle();

    // Freeze mid-digit, then resume.
    repeat (5) run_cycle();
    bus.enable = 1'b0;
    repeat (10) run_cycle();
    bus.enable = 1'b1;
    repeat (20) run_cycle();

    // Randomized digits, decimal points and enable gaps.
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) bus.digits_in = rand_digits();
      if ($urandom_range(0, 15) == 0) bus.dp_in = 4'($urandom);
      bus.enable = ($urandom_range(0, 4) != 0);
      run_cycle();
    end
    bus.enable = 1'b1;

    // Asynchronous reset mid-frame blanks at once; scanning restarts at digit 0.
    repeat (7) run_cycle();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_mid");
    bus.digits_in = rand_digits();
    reset = 1'b0;
    repeat (40) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
